// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write signals of the boot loader.
// master = upstream byte source / observer, slave = the loader itself.
interface prog_loader_if;
    logic       i_start;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_mem_we;
    logic [3:0] o_mem_addr;
    logic [7:0] o_mem_data;
    logic       o_cpu_run;
    logic       o_busy;
    logic       o_err;

    modport master (
        output i_start, i_valid, i_data,
        input  o_ready, o_mem_we, o_mem_addr, o_mem_data, o_cpu_run, o_busy, o_err
    );

    modport slave (
        input  i_start, i_valid, i_data,
        output o_ready, o_mem_we, o_mem_addr, o_mem_data, o_cpu_run, o_busy, o_err
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: header (MAGIC | N-1), N program bytes written to a 16x8 memory,
// then an 8-bit additive checksum; releases the CPU only on a matching checksum.
module prog_loader #(
    parameter logic [3:0] MAGIC = 4'hA
) (
    input logic          i_clk,
    input logic          i_rst,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WR, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] last_q,  last_d;
    logic [7:0] sum_q,   sum_d;
    logic [3:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;
    logic       ready;
    logic       accept;

    assign ready  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept = ready && bus.i_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (bus.i_start) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (bus.i_data[7:4] == MAGIC) begin
                        last_d  = bus.i_data[3:0];
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DATA: begin
                // Write address/data are registered here so they stay put after the strobe.
                if (accept) begin
                    addr_d  = cnt_q;
                    data_d  = bus.i_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                sum_d   = sum_q + data_q;
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == last_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (bus.i_data == sum_q) ? S_RUN : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_ready    = ready;
    assign bus.o_mem_we   = (state_q == S_WR);
    assign bus.o_mem_addr = addr_q;
    assign bus.o_mem_data = data_q;
    assign bus.o_cpu_run  = (state_q == S_RUN);
    assign bus.o_busy     = (state_q == S_HDR) || (state_q == S_DATA) ||
                            (state_q == S_WR)  || (state_q == S_CSUM);
    assign bus.o_err      = (state_q == S_ERR);
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: drivers queue expected memory writes,
// a negedge monitor pops and compares every write strobe it sees.
module tb_prog_loader;
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if lif ();

    prog_loader #(.MAGIC(4'hA)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (lif)
    );

    int         tests = 0;
    int         fails = 0;
    wr_t        sb_q[$];
    logic [7:0] tx_q[$];
    int         stream_cycles;
    wr_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (lif.o_mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         lif.o_mem_addr, lif.o_mem_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_addr", 32'(lif.o_mem_addr), 32'(mon_e.a));
                chk("wr_data", 32'(lif.o_mem_data), 32'(mon_e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        sb_q.push_back('{a: a, d: d});
    endtask

    task automatic start_load();
        @(negedge clk);
        lif.i_start = 1'b1;
        @(posedge clk);
        #1;
        lif.i_start = 1'b0;
    endtask

    // toggle=1: i_valid on odd cycles or during the write strobe, i_start held high throughout
    task automatic stream(input bit toggle);
        int   idx;
        int   cyc;
        logic v;
        idx = 0;
        cyc = 0;
        while (idx < tx_q.size() && cyc < 400) begin
            @(negedge clk);
            v = !toggle || (cyc % 2 == 1) || (lif.o_mem_we === 1'b1);
            lif.i_valid = v;
            lif.i_data  = tx_q[idx];
            lif.i_start = toggle;
            if (v && lif.o_ready === 1'b1) idx++;
            cyc++;
        end
        stream_cycles = cyc;
        if (idx < tx_q.size()) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: consumed %0d of %0d bytes", idx, tx_q.size());
        end
        @(negedge clk);
        lif.i_valid = 1'b0;
        lif.i_start = 1'b0;
        tx_q.delete();
    endtask

    task automatic check_end(input string name, input logic run, input logic err);
        @(negedge clk);
        chk({name, "_run"},   32'(lif.o_cpu_run), 32'(run));
        chk({name, "_err"},   32'(lif.o_err),     32'(err));
        chk({name, "_busy"},  32'(lif.o_busy),    32'd0);
        chk({name, "_ready"}, 32'(lif.o_ready),   32'd0);
        chk({name, "_sb"},    32'(sb_q.size()),   32'd0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ready"}, 32'(lif.o_ready),    32'd0);
        chk({name, "_we"},    32'(lif.o_mem_we),   32'd0);
        chk({name, "_addr"},  32'(lif.o_mem_addr), 32'd0);
        chk({name, "_data"},  32'(lif.o_mem_data), 32'd0);
        chk({name, "_run"},   32'(lif.o_cpu_run),  32'd0);
        chk({name, "_busy"},  32'(lif.o_busy),     32'd0);
        chk({name, "_err"},   32'(lif.o_err),      32'd0);
    endtask

    initial begin
        lif.i_start = 1'b0;
        lif.i_valid = 1'b0;
        lif.i_data  = 8'h00;
        rst = 1'b1;
        #2;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle stays idle without i_start, valid bytes ignored
        lif.i_valid = 1'b1;
        lif.i_data  = 8'hA2;
        repeat (4) @(negedge clk);
        chk("idle_busy",  32'(lif.o_busy),  32'd0);
        chk("idle_ready", 32'(lif.o_ready), 32'd0);
        lif.i_valid = 1'b0;

        // Basic 3-word load
        start_load();
        chk("hdr_busy",  32'(lif.o_busy),  32'd1);
        chk("hdr_ready", 32'(lif.o_ready), 32'd1);
        tx_q = '{8'hA2, 8'h15, 8'h2E, 8'hE0, 8'h23};
        push_wr(4'd0, 8'h15);
        push_wr(4'd1, 8'h2E);
        push_wr(4'd2, 8'hE0);
        stream(1'b0);
        check_end("load3", 1'b1, 1'b0);

        // Restart from RUN, then full 16-word load from address 0
        start_load();
        chk("restart_run",   32'(lif.o_cpu_run), 32'd0);
        chk("restart_busy",  32'(lif.o_busy),    32'd1);
        chk("restart_ready", 32'(lif.o_ready),   32'd1);
        tx_q.push_back(8'hAF);
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back(8'h10);
            push_wr(4'(i), 8'h10);
        end
        tx_q.push_back(8'h00);
        stream(1'b0);
        chk("load16_cycles", 32'(stream_cycles), 32'd34);
        check_end("load16", 1'b1, 1'b0);

        // Same load with a wrong checksum
        start_load();
        tx_q.push_back(8'hAF);
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back(8'h10);
            push_wr(4'(i), 8'h10);
        end
        tx_q.push_back(8'h01);
        stream(1'b0);
        check_end("badsum", 1'b0, 1'b1);

        // Bad header magic
        start_load();
        tx_q = '{8'h53};
        stream(1'b0);
        check_end("badhdr", 1'b0, 1'b1);
        start_load();
        chk("err_restart_err",  32'(lif.o_err),  32'd0);
        chk("err_restart_busy", 32'(lif.o_busy), 32'd1);

        // Gappy i_valid, held high during write strobes, i_start held high
        tx_q = '{8'hA1, 8'h33, 8'h44, 8'h77};
        push_wr(4'd0, 8'h33);
        push_wr(4'd1, 8'h44);
        stream(1'b1);
        check_end("toggle", 1'b1, 1'b0);

        // Asynchronous reset after the address-1 write strobe
        start_load();
        tx_q = '{8'hA3, 8'h01, 8'h02};
        push_wr(4'd0, 8'h01);
        push_wr(4'd1, 8'h02);
        stream(1'b0);
        @(posedge clk);
        #2;
        lif.i_valid = 1'b1;
        lif.i_data  = 8'h03;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_busy",  32'(lif.o_busy),  32'd0);
        chk("post_rst_ready", 32'(lif.o_ready), 32'd0);
        lif.i_valid = 1'b0;

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: MAGIC, 4'hA, required upper nibble of the header byte.
REQ-002 Port: i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_start  input  1  begin a load; sampled in IDLE, RUN, ERR only.
REQ-005 Port: i_valid  input  1  upstream byte present on i_data.
REQ-006 Port: i_data  input  8  upstream byte (header, program word, or checksum).
REQ-007 Port: o_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port: o_mem_we  output  1  one-cycle write strobe to the 16x8 program memory.
REQ-009 Port: o_mem_addr  output  4  program memory write address.
REQ-010 Port: o_mem_data  output  8  program memory write data.
REQ-011 Port: o_cpu_run  output  1  releases the CPU from hold; high only in RUN.
REQ-012 Port: o_busy  output  1  high in HDR, DATA, WR, CSUM.
REQ-013 Port: o_err  output  1  high only in ERR.

Function
REQ-014 A byte SHALL be accepted on a rising edge where i_valid and o_ready are both high; no other edge consumes i_data.
REQ-015 States SHALL be IDLE, HDR, DATA, WR, CSUM, RUN, ERR; o_ready is high in HDR, DATA, CSUM and low otherwise.
REQ-016 IDLE/RUN/ERR with i_start high SHALL go to HDR next cycle; o_cpu_run drops the same edge; sum, address and count clear.
REQ-017 i_start SHALL be ignored in HDR, DATA, WR, CSUM.
REQ-018 HDR accept: if i_data[7:4]==MAGIC, word count N=i_data[3:0]+1 (1..16), go to DATA; otherwise go to ERR.
REQ-019 DATA accept: byte latched, go to WR; WR lasts exactly one cycle.
REQ-020 In WR, o_mem_we SHALL be high with o_mem_addr=current address and o_mem_data=latched byte; o_mem_we is low in every other state.
REQ-021 In WR, the running sum SHALL update as sum=(sum+byte) mod 256 and the address increment by 1.
REQ-022 After WR: if N words have been written, go to CSUM; else DATA; address never wraps past N-1 within a load (N=16 ends at address 15).
REQ-023 CSUM accept: if i_data equals the 8-bit sum, go to RUN; otherwise go to ERR.
REQ-024 Minimum per-word cost SHALL be 2 cycles (accept + WR); full 16-word load with continuous i_valid completes in 1+32+1 accepting/writing cycles from HDR entry.
REQ-025 RUN and ERR SHALL persist until i_start or reset; o_mem_we never asserts there.
REQ-026 i_valid high in IDLE/RUN/ERR/WR SHALL have no effect (byte not consumed).
REQ-027 o_mem_addr/o_mem_data SHALL hold their last values outside WR.

Reset
REQ-028 On i_rst high, immediately and regardless of clock: state=IDLE, o_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_cpu_run=0, o_busy=0, o_err=0, sum=0, count=0.
REQ-029 Reset mid-load SHALL abort with no further write strobes; memory contents already written are not restored.
REQ-030 After reset release, the loader SHALL stay in IDLE until i_start.

Verification
REQ-031 Start, header 0xA2, data 0x15,0x2E,0xE0, checksum 0x23 -> writes (0,0x15),(1,0x2E),(2,0xE0) each a single we pulse, then o_cpu_run=1, o_err=0.
REQ-032 Header 0x53 -> ERR, o_err=1, no o_mem_we, o_cpu_run=0; then i_start -> HDR, o_err=0.
REQ-033 Header 0xAF, 16 bytes 0x10 each, checksum 0x00 -> addresses 0..15 written in order, RUN; checksum 0x01 instead -> ERR.
REQ-034 Header 0xA1, i_valid toggling every other cycle and held high during WR -> only 2 data bytes consumed, no byte lost or duplicated.
REQ-035 i_rst asserted asynchronously between WR of address 1 and 2 -> all outputs zero without a clock edge, no write to address 2.
REQ-036 In RUN, i_start pulse -> o_cpu_run low next edge, o_busy high, o_ready high, new load begins at address 0.
